// File: rtl/crossing_pkg.sv
// rtl/crossing_pkg.sv - shared types and constants for the level-crossing track arbiter
package crossing_pkg;

  typedef enum logic [2:0] {
    IDLE,
    WARN,
    LOWER,
    GRANT,
    OCCUPIED,
    RAISE
  } state_t;

  typedef enum logic {
    DIR_E = 1'b0,
    DIR_W = 1'b1
  } dir_t;

  localparam logic BARRIER_UP = 1'b1;
  localparam logic BARRIER_DN = 1'b0;

  function automatic dir_t opposite_dir(input dir_t d);
    return (d == DIR_E) ? DIR_W : DIR_E;
  endfunction

endpackage

// File: rtl/crossing_timer.sv
// rtl/crossing_timer.sv - loadable saturating up-counter with clear, enable and terminal-count compare
module crossing_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] tc_val,
  output logic [W-1:0] count,
  output logic         tc
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Saturate at all-ones so a long car blockage can never wrap back into the WARN window.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en && (count_q != {W{1'b1}})) begin
      count_d = count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign tc    = (count_q >= tc_val);

endmodule

// File: rtl/crossing_track_arbiter.sv
// rtl/crossing_track_arbiter.sv - single-track section arbiter sequencing lamps, barrier and signals
module crossing_track_arbiter
  import crossing_pkg::*;
#(
  parameter int WARN_CYC = 8,
  parameter int CAR_TO   = 16,
  parameter int HOLD_CYC = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic req_e,
  input  logic req_w,
  input  logic exit_e,
  input  logic exit_w,
  input  logic car,
  output logic grant_e,
  output logic grant_w,
  output logic barrier_ctrl,
  output logic lamp,
  output logic car_fault,
  output logic busy
);

  localparam int CNT_MAX = ((WARN_CYC + CAR_TO) > HOLD_CYC) ? (WARN_CYC + CAR_TO) : HOLD_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] WARN_TC  = CNT_W'(WARN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_TC  = CNT_W'(HOLD_CYC - 1);
  // Registered fault, so it is raised one count early to appear CAR_TO cycles past expiry.
  localparam logic [CNT_W-1:0] FAULT_TC = CNT_W'(WARN_CYC + CAR_TO - 2);

  state_t state_q, state_d;
  dir_t   sel_q, sel_d;
  dir_t   last_q, last_d;
  logic   grant_e_q, grant_e_d;
  logic   grant_w_q, grant_w_d;
  logic   barrier_q, barrier_d;
  logic   lamp_q, lamp_d;
  logic   car_fault_q, car_fault_d;
  logic   busy_q, busy_d;

  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] tc_val;
  logic             tc;
  logic             timer_clr;
  logic             req_sel;
  logic             far_exit;

  assign tc_val    = (state_q == RAISE) ? HOLD_TC : WARN_TC;
  assign timer_clr = (state_d != state_q) || (state_q == IDLE);

  crossing_timer #(.W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clr      (timer_clr),
    .en       (1'b1),
    .load     (1'b0),
    .load_val ({CNT_W{1'b0}}),
    .tc_val   (tc_val),
    .count    (count),
    .tc       (tc)
  );

  assign req_sel  = (sel_q == DIR_E) ? req_e : req_w;
  assign far_exit = (sel_q == DIR_E) ? exit_w : exit_e;

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (req_e || req_w) begin
          state_d = WARN;
          if (req_e && req_w) begin
            sel_d = opposite_dir(last_q);
          end else begin
            sel_d = req_e ? DIR_E : DIR_W;
          end
        end
      end
      WARN:     if (tc && !car) state_d = LOWER;
      LOWER:    state_d = GRANT;
      GRANT: begin
        if (!req_sel) begin
          state_d = OCCUPIED;
          last_d  = sel_q;
        end
      end
      OCCUPIED: if (far_exit) state_d = RAISE;
      RAISE:    if (tc) state_d = IDLE;
      default:  state_d = IDLE;
    endcase

    // Outputs are decoded from the next state so they change on the same edge as the state.
    grant_e_d   = (state_d == GRANT) && (sel_d == DIR_E);
    grant_w_d   = (state_d == GRANT) && (sel_d == DIR_W);
    barrier_d   = ((state_d == LOWER) || (state_d == GRANT) || (state_d == OCCUPIED))
                  ? BARRIER_DN : BARRIER_UP;
    lamp_d      = (state_d != IDLE);
    busy_d      = (state_d != IDLE);
    car_fault_d = (state_q == WARN) && car && (count >= FAULT_TC);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      sel_q       <= DIR_E;
      last_q      <= DIR_W;
      grant_e_q   <= 1'b0;
      grant_w_q   <= 1'b0;
      barrier_q   <= BARRIER_UP;
      lamp_q      <= 1'b0;
      car_fault_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      grant_e_q   <= grant_e_d;
      grant_w_q   <= grant_w_d;
      barrier_q   <= barrier_d;
      lamp_q      <= lamp_d;
      car_fault_q <= car_fault_d;
      busy_q      <= busy_d;
    end
  end

  assign grant_e      = grant_e_q;
  assign grant_w      = grant_w_q;
  assign barrier_ctrl = barrier_q;
  assign lamp         = lamp_q;
  assign car_fault    = car_fault_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_crossing_track_arbiter.sv
// tb/tb_crossing_track_arbiter.sv - self-checking bench for crossing_track_arbiter
module tb_crossing_track_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic req_e = 1'b0, req_w = 1'b0, exit_e = 1'b0, exit_w = 1'b0, car = 1'b0;
  logic grant_e, grant_w, barrier_ctrl, lamp, car_fault, busy;

  int checks = 0;
  int failures = 0;
  int exp_q[$];   // expected grant direction: 0 = E, 1 = W

  crossing_track_arbiter #(.WARN_CYC(8), .CAR_TO(16), .HOLD_CYC(4)) dut (
    .clk(clk), .rst(rst), .req_e(req_e), .req_w(req_w), .exit_e(exit_e), .exit_w(exit_w),
    .car(car), .grant_e(grant_e), .grant_w(grant_w), .barrier_ctrl(barrier_ctrl),
    .lamp(lamp), .car_fault(car_fault), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst) begin
      checks++;
      if ((grant_e && grant_w) !== 1'b0) begin
        failures++;
        $display("FAIL grant_overlap: grant_e=%b grant_w=%b required not both 1", grant_e, grant_w);
      end
      checks++;
      if (((grant_e || grant_w) && barrier_ctrl) !== 1'b0) begin
        failures++;
        $display("FAIL grant_with_barrier_up: grants=%b%b barrier=%b required barrier 0 when granted",
                 grant_e, grant_w, barrier_ctrl);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish within budget");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req_e = 1'b0; req_w = 1'b0; exit_e = 1'b0; exit_w = 1'b0; car = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  // dir = 0 for E, 1 for W, -1 on timeout; cycles = ticks until the grant appeared
  task automatic wait_grant(output int dir, output int cycles);
    bit done = 0;
    dir = -1;
    cycles = -1;
    for (int i = 1; i <= 200 && !done; i++) begin
      tick();
      if (grant_e) begin dir = 0; cycles = i; done = 1; end
      else if (grant_w) begin dir = 1; cycles = i; done = 1; end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (grant_e !== 1'b0) begin failures++; $display("FAIL reset_grant_e: got %b want 0", grant_e); end
    checks++; if (grant_w !== 1'b0) begin failures++; $display("FAIL reset_grant_w: got %b want 0", grant_w); end
    checks++; if (barrier_ctrl !== 1'b1) begin failures++; $display("FAIL reset_barrier: got %b want 1", barrier_ctrl); end
    checks++; if (lamp !== 1'b0) begin failures++; $display("FAIL reset_lamp: got %b want 0", lamp); end
    checks++; if (car_fault !== 1'b0) begin failures++; $display("FAIL reset_car_fault: got %b want 0", car_fault); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
  endtask

  task automatic test_single_east();
    int exp_dir;
    do_reset();
    req_e = 1'b1;
    exp_q.push_back(0);
    for (int t = 1; t <= 8; t++) begin
      tick();
      checks++;
      if ({lamp, barrier_ctrl, grant_e, busy} !== 4'b1101) begin
        failures++;
        $display("FAIL warn_phase t=%0d: lamp,barrier,grant_e,busy=%b want 1101", t, {lamp, barrier_ctrl, grant_e, busy});
      end
    end
    tick();
    checks++;
    if ({barrier_ctrl, grant_e, lamp} !== 3'b001) begin
      failures++;
      $display("FAIL lower_phase: barrier,grant_e,lamp=%b want 001", {barrier_ctrl, grant_e, lamp});
    end
    tick();
    exp_dir = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    checks++;
    if ({grant_e, grant_w} !== ((exp_dir == 0) ? 2'b10 : 2'b01)) begin
      failures++;
      $display("FAIL east_grant_cycle10: grant_e,grant_w=%b%b want dir %0d", grant_e, grant_w, exp_dir);
    end
    req_e = 1'b0;
    tick();
    checks++;
    if ({grant_e, barrier_ctrl, lamp} !== 3'b001) begin
      failures++;
      $display("FAIL east_occupied: grant_e,barrier,lamp=%b want 001", {grant_e, barrier_ctrl, lamp});
    end
    exit_w = 1'b1;
    tick();
    exit_w = 1'b0;
    checks++;
    if ({barrier_ctrl, lamp} !== 2'b11) begin
      failures++;
      $display("FAIL east_raise: barrier,lamp=%b want 11", {barrier_ctrl, lamp});
    end
    repeat (3) tick();
    checks++;
    if (lamp !== 1'b1) begin failures++; $display("FAIL hold_lamp_end: lamp=%b want 1", lamp); end
    tick();
    checks++;
    if ({lamp, busy, barrier_ctrl} !== 3'b001) begin
      failures++;
      $display("FAIL east_idle: lamp,busy,barrier=%b want 001", {lamp, busy, barrier_ctrl});
    end
  endtask

  task automatic test_conflict();
    int dir, cyc, exp_dir;
    do_reset();
    req_e = 1'b1; req_w = 1'b1;
    exp_q.push_back(0);
    exp_q.push_back(1);
    wait_grant(dir, cyc);
    exp_dir = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    checks++;
    if (dir !== exp_dir || cyc !== 10) begin
      failures++;
      $display("FAIL conflict_first: dir=%0d cycles=%0d want dir %0d cycles 10", dir, cyc, exp_dir);
    end
    req_e = 1'b0;
    tick();
    exit_w = 1'b1;
    tick();
    exit_w = 1'b0;
    wait_grant(dir, cyc);
    exp_dir = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    checks++;
    if (dir !== exp_dir || cyc !== 14) begin
      failures++;
      $display("FAIL conflict_second: dir=%0d cycles=%0d want dir %0d cycles 14", dir, cyc, exp_dir);
    end
    req_w = 1'b0;
    tick();
    exit_e = 1'b1;
    tick();
    exit_e = 1'b0;
    repeat (4) tick();
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL conflict_idle: busy=%b want 0", busy); end
  endtask

  task automatic test_car_and_occupied();
    int exp_dir;
    do_reset();
    car = 1'b1;
    req_w = 1'b1;
    exp_q.push_back(1);
    for (int t = 1; t <= 28; t++) begin
      tick();
      checks++;
      if ({barrier_ctrl, grant_w, car_fault} !== {1'b1, 1'b0, (t >= 24) ? 1'b1 : 1'b0}) begin
        failures++;
        $display("FAIL car_block t=%0d: barrier,grant_w,car_fault=%b want 10%b", t,
                 {barrier_ctrl, grant_w, car_fault}, (t >= 24));
      end
    end
    car = 1'b0;
    tick();
    checks++;
    if ({car_fault, barrier_ctrl} !== 2'b00) begin
      failures++;
      $display("FAIL car_clear_lower: car_fault,barrier=%b want 00", {car_fault, barrier_ctrl});
    end
    tick();
    exp_dir = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
    checks++;
    if ({grant_e, grant_w} !== ((exp_dir == 1) ? 2'b01 : 2'b10)) begin
      failures++;
      $display("FAIL car_then_grant: grant_e,grant_w=%b%b want dir %0d", grant_e, grant_w, exp_dir);
    end
    req_w = 1'b0;
    tick();
    exit_w = 1'b1;
    tick();
    exit_w = 1'b0;
    tick();
    checks++;
    if ({busy, barrier_ctrl, grant_w} !== 3'b100) begin
      failures++;
      $display("FAIL near_exit_ignored: busy,barrier,grant_w=%b want 100", {busy, barrier_ctrl, grant_w});
    end
    exit_e = 1'b1;
    tick();
    exit_e = 1'b0;
    checks++;
    if ({barrier_ctrl, lamp} !== 2'b11) begin
      failures++;
      $display("FAIL far_exit_raise: barrier,lamp=%b want 11", {barrier_ctrl, lamp});
    end
    repeat (4) tick();
    checks++;
    if ({lamp, busy} !== 2'b00) begin failures++; $display("FAIL car_test_idle: lamp,busy=%b want 00", {lamp, busy}); end
  endtask

  task automatic test_reset_mid_grant();
    int dir, cyc;
    do_reset();
    req_e = 1'b1;
    wait_grant(dir, cyc);
    checks++;
    if (dir !== 0) begin failures++; $display("FAIL pre_reset_grant: dir=%0d want 0", dir); end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({grant_e, grant_w, barrier_ctrl, lamp, busy} !== 5'b00100) begin
      failures++;
      $display("FAIL async_reset: grant_e,grant_w,barrier,lamp,busy=%b want 00100",
               {grant_e, grant_w, barrier_ctrl, lamp, busy});
    end
    req_e = 1'b0;
    #1 rst = 1'b1;
    tick();
    checks++;
    if ({busy, barrier_ctrl} !== 2'b01) begin
      failures++;
      $display("FAIL post_reset_idle: busy,barrier=%b want 01", {busy, barrier_ctrl});
    end
  endtask

  task automatic test_back_to_back();
    int dir, cyc, exp_dir;
    do_reset();
    req_e = 1'b1; req_w = 1'b1;
    for (int k = 0; k < 4; k++) exp_q.push_back(k % 2);
    for (int k = 0; k < 4; k++) begin
      wait_grant(dir, cyc);
      exp_dir = (exp_q.size() > 0) ? exp_q.pop_front() : -2;
      checks++;
      if (dir !== exp_dir) begin
        failures++;
        $display("FAIL alternation seq=%0d: dir=%0d want %0d", k, dir, exp_dir);
      end
      // The granted train passes, and a fresh train arrives at the same signal.
      if (dir == 0) req_e = 1'b0; else req_w = 1'b0;
      tick();
      req_e = 1'b1; req_w = 1'b1;
      if (dir == 0) exit_w = 1'b1; else exit_e = 1'b1;
      tick();
      exit_e = 1'b0; exit_w = 1'b0;
    end
    checks++;
    if (exp_q.size() !== 0) begin failures++; $display("FAIL scoreboard_drain: left=%0d want 0", exp_q.size()); end
    req_e = 1'b0; req_w = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_east();
    test_conflict();
    test_car_and_occupied();
    test_reset_mid_grant();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
